// File: rtl/audio_out_dac.sv
// audio_out_dac: frame FIFO with per-sample-period pop, driving one
// PWM or first-order sigma-delta 1-bit output per channel.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   in_data         one frame, channel k at [k*WIDTH +: WIDTH]
//   in_valid        frame present
//   in_ready        FIFO can accept a frame (0 during reset)
//   mode            0 = PWM, 1 = sigma-delta (all channels)
//   clr_underrun    clears the sticky underrun flag
//   analog          registered 1-bit modulated outputs
//   level           frames currently buffered
//   underrun        sticky: a sample tick found the FIFO empty

module audio_out_dac #(
  parameter int CHANNELS   = 2,
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int SAMPLE_DIV = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS*WIDTH-1:0]   in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        mode,
  input  logic                        clr_underrun,
  output logic [CHANNELS-1:0]         analog,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        underrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int FW = CHANNELS * WIDTH;

  logic [FW-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [DW-1:0]    div_cnt;
  logic [WIDTH-1:0] pwm_cnt;
  logic [WIDTH-1:0] hold [CHANNELS];
  logic [WIDTH-1:0] acc  [CHANNELS];
  logic [WIDTH:0]   sum  [CHANNELS];
  logic             tick;
  logic             empty;
  logic             push;
  logic             pop;

  // Ready comes from the registered count only; held low in reset.
  assign in_ready = !rst && (level != LW'(FIFO_DEPTH));
  assign tick     = (div_cnt == DW'(SAMPLE_DIV - 1));
  assign empty    = (level == '0);
  assign push     = in_valid && in_ready;
  // The pop looks at the pre-push count, so a push on an empty
  // tick stays queued and the tick still counts as an underrun.
  assign pop      = tick && !empty;

  // Frame storage: not reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      div_cnt  <= '0;
      underrun <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        level <= level + LW'(1);
      end else if (pop && !push) begin
        level <= level - LW'(1);
      end
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
      // Set beats clear when both land on the same edge.
      if (tick && empty) begin
        underrun <= 1'b1;
      end else if (clr_underrun) begin
        underrun <= 1'b0;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      sum[k] = {1'b0, acc[k]} + {1'b0, hold[k]};
    end
  end

  // pwm_cnt and the accumulators run in both modes so a mode
  // change never restarts either modulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      analog  <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        hold[k] <= '0;
        acc[k]  <= '0;
      end
    end else begin
      pwm_cnt <= pwm_cnt + WIDTH'(1);
      for (int k = 0; k < CHANNELS; k++) begin
        acc[k] <= sum[k][WIDTH-1:0];
        if (mode) begin
          analog[k] <= sum[k][WIDTH];
        end else begin
          analog[k] <= (pwm_cnt < hold[k]);
        end
        if (pop) begin
          hold[k] <= mem[rd_ptr][k*WIDTH +: WIDTH];
        end
      end
    end
  end

endmodule

// File: doc/audio_out_dac.md
# audio_out_dac

Multi-channel audio output stage: buffers interleaved sample frames in a frame FIFO, releases one frame per sample period, and drives one 1-bit modulated output per channel. Each channel runs in PWM or first-order sigma-delta mode, selected at runtime. It sits between the SPI/SD data path and the board's RC-filtered analog pins. It generalises the single-channel PWM DAC with channel count, width, buffering, sample pacing and a second modulation mode.

## Interface

- CHANNELS, 2: number of output channels (≥1)
- WIDTH, 8: sample width in bits, unsigned (offset-binary)
- FIFO_DEPTH, 16: frame FIFO depth, power of 2, ≥2
- SAMPLE_DIV, 256: clocks per sample period (≥2)

- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- in_data  in  CHANNELS*WIDTH  one frame; channel k at [k*WIDTH +: WIDTH]
- in_valid  in  1  frame present
- in_ready  out  1  FIFO can accept a frame
- mode  in  1  0 = PWM, 1 = sigma-delta
- clr_underrun  in  1  clears sticky underrun flag
- analog  out  CHANNELS  modulated 1-bit outputs, registered
- level  out  $clog2(FIFO_DEPTH)+1  frames currently buffered
- underrun  out  1  sticky: a sample tick found the FIFO empty

## Operation

- Push: a frame is written when in_valid && in_ready. in_ready = (level != FIFO_DEPTH), combinational from registered count. It is 0 while rst is high.
- Sample pacing: div_cnt counts 0..SAMPLE_DIV-1 and wraps. tick = (div_cnt == SAMPLE_DIV-1).
- Pop on tick:
  - If level > 0, the head frame is popped into the per-channel hold registers.
  - If level == 0, the hold registers keep their last value and underrun is set.
- level: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Push and tick in the same cycle:
  - Empty FIFO: the pop sees the old count (0), so underrun fires and the pushed frame stays queued.
  - Full FIFO: in_ready is already 0, so no push occurs; the pop proceeds.
- underrun: set on an empty tick, cleared by clr_underrun. If both occur in the same cycle, set wins.
- PWM mode: pwm_cnt is a WIDTH-bit free-running counter shared by all channels. analog[k] <= (pwm_cnt < hold[k]).
  - hold = 0 gives constant 0.
  - hold = 2^WIDTH-1 gives high for 2^WIDTH-1 of every 2^WIDTH clocks.
- Sigma-delta mode: per channel, sum = {1'b0,acc[k]} + {1'b0,hold[k]}; analog[k] <= sum[WIDTH]; acc[k] <= sum[WIDTH-1:0].
  - Over 2^WIDTH clocks the output is high for exactly hold[k] cycles.
- Shared counters: pwm_cnt and every acc update every cycle in both modes. A mode change takes effect on the next analog update, with no counter or accumulator reset.
- FIFO storage: circular buffer with log2(FIFO_DEPTH)-bit read/write pointers that wrap naturally. Storage is not cleared by reset.

## Timing

- Reset (rst high at a clk edge) forces:
  - analog = 0, level = 0, underrun = 0, in_ready = 0
  - hold = 0, acc = 0, pwm_cnt = 0, div_cnt = 0, pointers = 0
- First cycle after reset: in_ready = 1.
- Reset mid-operation discards all buffered frames and restarts pacing, so the first tick comes SAMPLE_DIV cycles after rst deasserts.
- Push latency: a push at edge N updates level at edge N; the frame is poppable by a tick in cycle N+1 or later.
- Tick to output: the pop loads hold at the tick edge. analog reflects the new hold at the following edge (1 cycle registered).
- Tick spacing: exactly SAMPLE_DIV cycles, independent of FIFO state.
- clr_underrun takes effect at the next edge.

## Test plan

- Reset/idle, CHANNELS=2, WIDTH=8: hold rst 3 cycles, then release.
  - During rst: analog=0, level=0, in_ready=0, underrun=0.
  - First cycle after: in_ready=1.
  - At the first tick: underrun=1.
  - After clr_underrun: underrun=0 next cycle, then re-set at the following tick.
- PWM duty, mode=0: push frame {ch1=8'hC0, ch0=8'h40}, wait for tick.
  - Over the next 256 cycles: analog[0] high 64 cycles, analog[1] high 192 cycles.
  - With 8'h00 / 8'hFF: 0 and 255 cycles high.
- Sigma-delta, mode=1: hold ch0=8'h01.
  - analog[0] high exactly 1 cycle per 256.
  - With 8'h80: output alternates every cycle once acc has settled.
- Fill/full, FIFO_DEPTH=16, mode=1: push 16 frames with no tick.
  - level=16, in_ready=0, a 17th in_valid is not accepted.
  - The tick pops frames in push order; level=15 and in_ready=1 the next cycle.
  - Pointer wrap: after 40 push/pop frames, contents stay in order.
- Simultaneous events:
  - Push and tick on the same edge with level=0: underrun=1, level=1, hold unchanged.
  - Push and tick with level=5: level stays 5.
- Mode switch mid-period: toggle mode with hold=8'h40. No glitch beyond one cycle; pwm_cnt and acc continue unchanged (check counter values).
